iram_fetch_arbiter: RTL and testbench
=====================================

# iram_fetch_arbiter

Round-robin arbiter that shares the single read port of the instruction memory among the N processing cores of the N-core matrix-multiplication array. Each core presents a fetch request with an instruction address. The arbiter grants at most one core per cycle, drives the memory's read-enable and address, and returns a per-core valid aligned with the memory's registered 1-cycle read data. Sustained throughput is one fetch per cycle, and every requesting core is served within N_CORES cycles.

## Interface
- N_CORES, 4, number of requesting cores (2..16)
- ADDR_W, 8, instruction address width (256 locations)
- DATA_W, 8, instruction word width
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- en  input  1  arbitration enable; 0 = no new grants
- req  input  N_CORES  per-core fetch request, held until granted
- req_addr  input  N_CORES*ADDR_W  core k address in bits [k*ADDR_W +: ADDR_W]
- gnt  output  N_CORES  one-hot (or zero) grant, combinational, same cycle as issue
- rvalid  output  N_CORES  registered; core k's instruction is on rdata this cycle
- rdata  output  DATA_W  broadcast instruction, equals iram_data
- iram_read  output  1  read enable to instruction memory (read_IRAM)
- iram_addr  output  ADDR_W  address to instruction memory
- iram_data  input  DATA_W  registered instruction from memory (instr_out)
- fetch_cnt  output  16  total grants since reset, saturating at 16'hFFFF

## Operation
- State: priority pointer ptr (clog2(N_CORES) bits), rvalid register, fetch_cnt.
- Arbitration (combinational): if rst_n=1, en=1 and req!=0, grant the first requesting core found scanning ptr, ptr+1, ..., wrapping modulo N_CORES. Otherwise gnt=0.
- On grant to core k:
  - iram_read=1 and iram_addr=req_addr[k].
  - Next edge: ptr <= (k+1) mod N_CORES, rvalid <= one-hot(k), fetch_cnt <= fetch_cnt+1 unless already 16'hFFFF.
- No grant: iram_read=0, iram_addr=0, ptr unchanged, rvalid <= 0.
- rdata is a direct pass-through of iram_data. The memory holds instr_out while its read is low, so rdata is meaningful only while some rvalid bit is high.
- Handshake:
  - A core keeps req high and req_addr stable until it sees gnt[k]=1.
  - The core may drop req, or present a new address, in the following cycle.
  - A core may hold req high continuously and receive back-to-back fetches, subject to round-robin rotation.
- Fairness: a core whose req stays high is granted within N_CORES cycles of its request while en=1.
- en=0:
  - Blocks only new grants.
  - An rvalid already scheduled for the next cycle still asserts.
  - ptr is frozen.
- Requests dropped before being granted are legal; no state is kept for them.

## Timing
- Cycle T: gnt[k]=1 and iram_read=1. Cycle T+1: rvalid[k]=1 and rdata holds the instruction at req_addr[k]. Fetch latency is 1 cycle.
- At most one rvalid bit is high in any cycle. rvalid is never high in two consecutive cycles for different cores unless a grant occurred in each of the preceding cycles.
- Reset values (asynchronous, immediate on rst_n=0): ptr=0, rvalid=0, fetch_cnt=0. Combinational outputs are forced as well: gnt=0, iram_read=0, iram_addr=0.
- Reset mid-fetch: a grant issued in the cycle reset asserts produces no rvalid, and the pending read is dropped. After rst_n rises, the first grant scans from core 0.
- Only one requester: it is granted every cycle, regardless of ptr.
- ptr wrap: a grant to core N_CORES-1 sets ptr=0.

## Test plan
- Single request (N_CORES=4): memory preloaded with ram[3]=8 and ram[4]=8'd0. Core 2 requests addr 3 at T; core 0 requests addr 4 at T+1.
  - T: gnt=4'b0100, iram_addr=3.
  - T+1: rvalid=4'b0100, rdata=8; also gnt=4'b0001, iram_addr=4.
  - T+2: rvalid=4'b0001, rdata=0.
- All four cores hold req=4'b1111 from reset for 8 cycles -> grant order 0,1,2,3,0,1,2,3; rvalid follows one cycle later; fetch_cnt=8.
- ptr=2 with req=4'b0011 -> gnt=4'b0001 (wrap), then ptr=1 and the next grant goes to core 1.
- en deasserted in the cycle after a grant to core 3 -> rvalid=4'b1000 still asserts; no further gnt while en=0 with req=4'b1111; after en=1 the first grant is core 0 (ptr=0).
- rst_n pulsed low in the same cycle as a grant to core 1 -> gnt, iram_read and rvalid read 0 immediately and stay 0 the next cycle; after release with req=4'b0110, the first grant is core 1.
- fetch_cnt forced near saturation: 65535 grants, then 3 more -> holds at 16'hFFFF.

Source files
------------

// File: rtl/iram_fetch_arbiter.sv
// iram_fetch_arbiter: round-robin arbiter sharing the instruction memory read port among N cores
module iram_fetch_arbiter #(
    parameter int N_CORES = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic [N_CORES-1:0]          req,
    input  logic [N_CORES*ADDR_W-1:0]   req_addr,
    output logic [N_CORES-1:0]          gnt,
    output logic [N_CORES-1:0]          rvalid,
    output logic [DATA_W-1:0]           rdata,
    output logic                        iram_read,
    output logic [ADDR_W-1:0]           iram_addr,
    input  logic [DATA_W-1:0]           iram_data,
    output logic [15:0]                 fetch_cnt
);
    localparam int PW = (N_CORES > 1) ? $clog2(N_CORES) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] sel;
    logic [PW:0]   c;
    logic          hit;

    // Scan ptr, ptr+1, ... modulo N_CORES; the first requester wins.
    always_comb begin
        gnt = '0;
        sel = '0;
        hit = 1'b0;
        c   = '0;
        for (int i = 0; i < N_CORES; i++) begin
            c = {1'b0, ptr} + (PW+1)'(i);
            if (c >= (PW+1)'(N_CORES)) c = c - (PW+1)'(N_CORES);
            if (!hit && rst_n && en && req[c[PW-1:0]]) begin
                hit            = 1'b1;
                gnt[c[PW-1:0]] = 1'b1;
                sel            = c[PW-1:0];
            end
        end
    end

    assign iram_read = hit;
    assign iram_addr = hit ? req_addr[sel*ADDR_W +: ADDR_W] : '0;
    assign rdata     = iram_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            rvalid    <= '0;
            fetch_cnt <= '0;
        end else begin
            rvalid <= gnt;
            if (hit) begin
                ptr       <= (sel == PW'(N_CORES-1)) ? '0 : sel + PW'(1);
                fetch_cnt <= (fetch_cnt == 16'hFFFF) ? fetch_cnt : fetch_cnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_iram_fetch_arbiter.sv
// tb_iram_fetch_arbiter: table-driven directed checks of the instruction fetch arbiter
module tb_iram_fetch_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] req_addr = '0;
    logic [3:0]  gnt, rvalid;
    logic [7:0]  rdata, iram_addr;
    logic        iram_read;
    logic [7:0]  iram_data = '0;
    logic [15:0] fetch_cnt;
    logic [7:0]  mem [256];

    int checks = 0;
    int errors = 0;
    int row = 0;

    typedef struct {
        logic        rst_n;
        logic        en;
        logic [3:0]  req;
        logic [31:0] ra;
        logic [3:0]  g;
        logic [7:0]  a;
        logic [3:0]  rv;
        logic [7:0]  rd;
        logic [15:0] cnt;
    } vec_t;

    vec_t vq[$];

    iram_fetch_arbiter #(.N_CORES(4), .ADDR_W(8), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req), .req_addr(req_addr),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .iram_read(iram_read),
        .iram_addr(iram_addr), .iram_data(iram_data), .fetch_cnt(fetch_cnt)
    );

    always #5 clk = ~clk;

    // Instruction memory with a registered read that holds while read is low.
    always @(posedge clk) if (iram_read) iram_data <= mem[iram_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (row %0d): got %0h expected %0h", name, row, act, exp);
        end
    endtask

    localparam logic [31:0] STD = 32'h281E140A;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i + 16);
        mem[3] = 8'd8;
        mem[4] = 8'd0;
        //                rst en req      ra            gnt      addr   rvalid   rdata  cnt
        vq.push_back('{1'b0, 1'b1, 4'b1111, STD,          4'b0000, 8'd0,  4'b0000, 8'd0,  16'd0});
        vq.push_back('{1'b1, 1'b1, 4'b0100, 32'h00030000, 4'b0100, 8'd3,  4'b0000, 8'd0,  16'd0});
        vq.push_back('{1'b1, 1'b1, 4'b0001, 32'h00000004, 4'b0001, 8'd4,  4'b0100, 8'd8,  16'd1});
        vq.push_back('{1'b1, 1'b1, 4'b0000, 32'h00000000, 4'b0000, 8'd0,  4'b0001, 8'd0,  16'd2});
        vq.push_back('{1'b0, 1'b1, 4'b1111, STD,          4'b0000, 8'd0,  4'b0000, 8'd0,  16'd0});
        vq.push_back('{1'b1, 1'b1, 4'b1111, STD,          4'b0001, 8'd10, 4'b0000, 8'd0,  16'd0});
        vq.push_back('{1'b1, 1'b1, 4'b1111, STD,          4'b0010, 8'd20, 4'b0001, 8'd26, 16'd1});
        vq.push_back('{1'b1, 1'b1, 4'b1111, STD,          4'b0100, 8'd30, 4'b0010, 8'd36, 16'd2});
        vq.push_back('{1'b1, 1'b1, 4'b1111, STD,          4'b1000, 8'd40, 4'b0100, 8'd46, 16'd3});
        vq.push_back('{1'b1, 1'b1, 4'b1111, STD,          4'b0001, 8'd10, 4'b1000, 8'd56, 16'd4});
        vq.push_back('{1'b1, 1'b1, 4'b1111, STD,          4'b0010, 8'd20, 4'b0001, 8'd26, 16'd5});
        vq.push_back('{1'b1, 1'b1, 4'b1111, STD,          4'b0100, 8'd30, 4'b0010, 8'd36, 16'd6});
        vq.push_back('{1'b1, 1'b1, 4'b1111, STD,          4'b1000, 8'd40, 4'b0100, 8'd46, 16'd7});
        vq.push_back('{1'b1, 1'b1, 4'b0000, STD,          4'b0000, 8'd0,  4'b1000, 8'd56, 16'd8});
        vq.push_back('{1'b1, 1'b1, 4'b0010, STD,          4'b0010, 8'd20, 4'b0000, 8'd0,  16'd8});
        vq.push_back('{1'b1, 1'b1, 4'b0011, STD,          4'b0001, 8'd10, 4'b0010, 8'd36, 16'd9});
        vq.push_back('{1'b1, 1'b1, 4'b0011, STD,          4'b0010, 8'd20, 4'b0001, 8'd26, 16'd10});
        vq.push_back('{1'b1, 1'b1, 4'b1000, STD,          4'b1000, 8'd40, 4'b0010, 8'd36, 16'd11});
        vq.push_back('{1'b1, 1'b0, 4'b1111, STD,          4'b0000, 8'd0,  4'b1000, 8'd56, 16'd12});
        vq.push_back('{1'b1, 1'b0, 4'b1111, STD,          4'b0000, 8'd0,  4'b0000, 8'd0,  16'd12});
        vq.push_back('{1'b1, 1'b1, 4'b1111, STD,          4'b0001, 8'd10, 4'b0000, 8'd0,  16'd12});
        vq.push_back('{1'b1, 1'b1, 4'b1111, STD,          4'b0010, 8'd20, 4'b0001, 8'd26, 16'd13});

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            row      = i;
            rst_n    = vq[i].rst_n;
            en       = vq[i].en;
            req      = vq[i].req;
            req_addr = vq[i].ra;
            #1;
            chk("gnt", 32'(gnt), 32'(vq[i].g));
            chk("iram_read", 32'(iram_read), 32'(vq[i].g != 4'b0000));
            chk("iram_addr", 32'(iram_addr), 32'(vq[i].a));
            chk("rvalid", 32'(rvalid), 32'(vq[i].rv));
            chk("fetch_cnt", 32'(fetch_cnt), 32'(vq[i].cnt));
            if (vq[i].rv != 4'b0000) chk("rdata", 32'(rdata), 32'(vq[i].rd));
        end

        // Reset asserted in the same cycle as a grant to core 1.
        row = 100;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_read", 32'(iram_read), 32'h0);
        chk("rst_addr", 32'(iram_addr), 32'h0);
        chk("rst_rvalid", 32'(rvalid), 32'h0);
        chk("rst_cnt", 32'(fetch_cnt), 32'h0);
        @(negedge clk); #1;
        chk("rst_rvalid_next", 32'(rvalid), 32'h0);
        chk("rst_gnt_next", 32'(gnt), 32'h0);
        rst_n = 1'b1;
        req   = 4'b0110;
        #1;
        chk("post_rst_gnt", 32'(gnt), 32'b0010);
        chk("post_rst_addr", 32'(iram_addr), 32'd20);
        @(negedge clk); #1;
        chk("post_rst_rvalid", 32'(rvalid), 32'b0010);
        chk("post_rst_rdata", 32'(rdata), 32'd36);
        chk("post_rst_gnt2", 32'(gnt), 32'b0100);

        // Saturation of fetch_cnt with a single continuous requester.
        row = 200;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;
        req   = 4'b0001;
        repeat (65534) @(posedge clk);
        #1;
        chk("cnt_fffe", 32'(fetch_cnt), 32'hFFFE);
        chk("single_gnt", 32'(gnt), 32'b0001);
        @(posedge clk); #1;
        chk("cnt_ffff", 32'(fetch_cnt), 32'hFFFF);
        repeat (3) @(posedge clk);
        #1;
        chk("cnt_hold", 32'(fetch_cnt), 32'hFFFF);
        chk("sat_rvalid", 32'(rvalid), 32'b0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
